spi_master_modes: RTL and testbench

SPI_MASTER_MODES -- requirements
Module: spi_master_modes

---
 rtl/spi_master_pkg.sv | 26 ++
 rtl/spi_mode_shreg.sv | 28 ++
 rtl/spi_master_modes.sv | 169 ++++++++++++++++
 tb/tb_spi_master_modes.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared definitions for the multi-mode SPI master:
// state encoding, mode bit positions and reset defaults.
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        PHASE_A,
        PHASE_B,
        CS_HOLD,
        DONE
    } spi_state_e;

    localparam int MODE_CPOL = 1;
    localparam int MODE_CPHA = 0;

    // Packet size resets to the NBITS parameter of the instance.
    localparam logic [1:0] RST_MODE = 2'b00;
    localparam int RST_CS_ADDR = 0;
    localparam int RST_DIV = 0;

    function automatic int sat_size(input int size, input int nbits);
        return (size > nbits) ? nbits : size;
    endfunction

endpackage

// File: rtl/spi_mode_shreg.sv
// Left-shifting serial register with clear, parallel load and serial
// input; clear wins over load, load wins over shift.
module spi_mode_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift_en,
    input  logic         sin,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {q[W-2:0], sin};
        end
    end

endmodule

// File: rtl/spi_master_modes.sv
// SPI master supporting all four CPOL/CPHA modes, with programmable
// packet length, chip select and SCLK divider.
module spi_master_modes
    import spi_master_pkg::*;
#(
    parameter int NBITS = 34,
    parameter int NCS = 1,
    parameter int DIVW = 8,
    localparam int LOGBITSN = $clog2(NBITS) + 1,
    localparam int LOGCSN = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic [NCS-1:0]      spi_ifc_cs,
    output logic                spi_ifc_sclk,
    output logic                spi_ifc_mosi,
    input  logic                spi_ifc_miso,
    input  logic                recv_val,
    output logic                recv_rdy,
    input  logic [NBITS-1:0]    recv_msg,
    output logic                send_val,
    input  logic                send_rdy,
    output logic [NBITS-1:0]    send_msg,
    input  logic                cfg_val,
    output logic                cfg_rdy,
    input  logic [LOGBITSN-1:0] cfg_packet_size,
    input  logic [LOGCSN-1:0]   cfg_cs_addr,
    input  logic [1:0]          cfg_mode,
    input  logic [DIVW-1:0]     cfg_div
);

    spi_state_e state, state_n;

    logic [DIVW-1:0]     cnt, div_q;
    logic [LOGBITSN-1:0] size_q, bcnt, n_next;
    logic [LOGCSN-1:0]   cs_addr_q;
    logic [1:0]          mode_q;
    logic [NBITS-1:0]    tx_q, tx_load;
    logic                cfg_fire, recv_fire, send_fire;
    logic                tick, cs_active, cpol, cpha;
    logic                tx_shift, rx_shift, tx_unused;

    assign cfg_rdy  = (state == IDLE) || (state == DONE);
    assign recv_rdy = (state == IDLE) || ((state == DONE) && send_rdy);
    assign send_val = (state == DONE);

    assign cfg_fire  = cfg_val && cfg_rdy;
    assign recv_fire = recv_val && recv_rdy;
    assign send_fire = send_val && send_rdy;

    assign cpol = mode_q[MODE_CPOL];
    assign cpha = mode_q[MODE_CPHA];
    assign tick = (cnt == div_q);

    assign cs_active = (state == CS_SETUP) || (state == PHASE_A)
                    || (state == PHASE_B) || (state == CS_HOLD);

    // A cfg beat accepted with the request applies to that request.
    assign n_next = LOGBITSN'(sat_size(
        int'(cfg_fire ? cfg_packet_size : size_q), NBITS));
    assign tx_load = recv_msg << (LOGBITSN'(NBITS) - n_next);

    always_comb begin
        spi_ifc_cs = '1;
        for (int i = 0; i < NCS; i++) begin
            spi_ifc_cs[i] = !(cs_active && (int'(cs_addr_q) == i));
        end
    end

    assign spi_ifc_sclk = (state == PHASE_A) ? ~cpol : cpol;
    assign spi_ifc_mosi = cs_active && tx_q[NBITS-1];
    assign tx_unused    = ^tx_q[NBITS-2:0];

    always_comb begin
        state_n  = state;
        tx_shift = 1'b0;
        rx_shift = 1'b0;
        unique case (state)
            IDLE: begin
                if (recv_fire) state_n = CS_SETUP;
            end
            CS_SETUP: begin
                if (tick) begin
                    if (bcnt == '0) begin
                        state_n = CS_HOLD;
                    end else begin
                        state_n  = PHASE_A;
                        rx_shift = ~cpha;
                    end
                end
            end
            PHASE_A: begin
                if (tick) begin
                    state_n  = PHASE_B;
                    rx_shift = cpha;
                    tx_shift = ~cpha && (bcnt != LOGBITSN'(1));
                end
            end
            PHASE_B: begin
                if (tick) begin
                    if (bcnt == LOGBITSN'(1)) begin
                        state_n = CS_HOLD;
                    end else begin
                        state_n  = PHASE_A;
                        tx_shift = cpha;
                        rx_shift = ~cpha;
                    end
                end
            end
            CS_HOLD: begin
                if (tick) state_n = DONE;
            end
            DONE: begin
                if (recv_fire) state_n = CS_SETUP;
                else if (send_fire) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bcnt      <= '0;
            size_q    <= LOGBITSN'(NBITS);
            cs_addr_q <= LOGCSN'(RST_CS_ADDR);
            mode_q    <= RST_MODE;
            div_q     <= DIVW'(RST_DIV);
        end else begin
            state <= state_n;
            cnt   <= (tick || !cs_active) ? '0 : cnt + DIVW'(1);
            if (recv_fire) begin
                bcnt <= n_next;
            end else if ((state == PHASE_B) && tick) begin
                bcnt <= bcnt - LOGBITSN'(1);
            end
            if (cfg_fire) begin
                size_q    <= cfg_packet_size;
                cs_addr_q <= cfg_cs_addr;
                mode_q    <= cfg_mode;
                div_q     <= cfg_div;
            end
        end
    end

    spi_mode_shreg #(.W(NBITS)) u_tx (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .load     (recv_fire),
        .load_val (tx_load),
        .shift_en (tx_shift),
        .sin      (1'b0),
        .q        (tx_q)
    );

    spi_mode_shreg #(.W(NBITS)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .clear    (recv_fire),
        .load     (1'b0),
        .load_val ('0),
        .shift_en (rx_shift),
        .sin      (spi_ifc_miso),
        .q        (send_msg)
    );

endmodule

// File: tb/tb_spi_master_modes.sv
// Self-checking bench: acts as an SPI slave with independent data and
// checks framing, edge counts, bit order and handshakes.
module tb_spi_master_modes;

    localparam int NB   = 34;
    localparam int NCS  = 3;
    localparam int DIVW = 8;
    localparam int LB   = $clog2(NB) + 1;
    localparam int LC   = (NCS > 1) ? $clog2(NCS) : 1;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [NCS-1:0] cs;
    logic           sclk, mosi, miso;
    logic           recv_val, recv_rdy, send_val, send_rdy;
    logic [NB-1:0]  recv_msg, send_msg;
    logic           cfg_val, cfg_rdy;
    logic [LB-1:0]  cfg_packet_size;
    logic [LC-1:0]  cfg_cs_addr;
    logic [1:0]     cfg_mode;
    logic [DIVW-1:0] cfg_div;

    logic loop_en = 1'b0;
    logic slave_bit = 1'b0;
    assign miso = loop_en ? mosi : slave_bit;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    spi_master_modes #(.NBITS(NB), .NCS(NCS), .DIVW(DIVW)) dut (
        .clk             (clk),
        .reset           (reset),
        .spi_ifc_cs      (cs),
        .spi_ifc_sclk    (sclk),
        .spi_ifc_mosi    (mosi),
        .spi_ifc_miso    (miso),
        .recv_val        (recv_val),
        .recv_rdy        (recv_rdy),
        .recv_msg        (recv_msg),
        .send_val        (send_val),
        .send_rdy        (send_rdy),
        .send_msg        (send_msg),
        .cfg_val         (cfg_val),
        .cfg_rdy         (cfg_rdy),
        .cfg_packet_size (cfg_packet_size),
        .cfg_cs_addr     (cfg_cs_addr),
        .cfg_mode        (cfg_mode),
        .cfg_div         (cfg_div)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic gap(input int k);
        for (int g = 0; g < k; g++) begin
            @(negedge clk);
            chk("idle_send_val", send_val, 0);
            chk("idle_recv_rdy", recv_rdy, 1);
            chk("idle_cfg_rdy", cfg_rdy, 1);
        end
    endtask

    // One transaction: cfg and request accepted together, then the bench
    // plays slave, presenting sd MSB-first on miso and capturing mosi.
    task automatic xfer(input logic [NB-1:0] msg, input int size,
                        input logic [1:0] mode, input int div,
                        input int csa, input bit loop,
                        input logic [63:0] sd, input int stall,
                        input bit poke);
        int n, lead, trail, cs_low, other_bad, act, k, budget;
        logic [63:0] mask, sdata, exp_rx, mosi_got;
        logic cpol, cpha, prev, done;
        n = (size > NB) ? NB : size;
        mask = (64'd1 << n) - 64'd1;
        sdata = sd & mask;
        cpol = mode[1];
        cpha = mode[0];
        exp_rx = loop ? (64'(msg) & mask) : sdata;
        cfg_val = 1'b1;
        cfg_packet_size = LB'(size);
        cfg_cs_addr = LC'(csa);
        cfg_mode = mode;
        cfg_div = DIVW'(div);
        recv_val = 1'b1;
        recv_msg = msg;
        send_rdy = 1'b1;
        loop_en = loop;
        #1;
        chk("recv_rdy_start", recv_rdy, 1);
        chk("cfg_rdy_start", cfg_rdy, 1);
        @(negedge clk);
        cfg_val = 1'b0;
        recv_val = 1'b0;
        send_rdy = (stall == 0);
        lead = 0; trail = 0; cs_low = 0; other_bad = 0; act = 0; k = 0;
        mosi_got = '0;
        prev = cpol;
        done = 1'b0;
        if (csa < NCS) chk("cs_start", cs[csa], 0);
        chk("sclk_idle_level", sclk, cpol);
        if (!cpha && n > 0) begin
            slave_bit = sdata[n-1];
            k = 1;
        end
        budget = (2 * n + 2) * (div + 1) + 8;
        for (int c = 0; c < budget && !done; c++) begin
            cfg_val = 1'b0;
            if (send_val) begin
                done = 1'b1;
            end else begin
                for (int i = 0; i < NCS; i++)
                    if (i != csa && cs[i] == 1'b0) other_bad++;
                if (csa < NCS && cs[csa] == 1'b0) cs_low++;
                if (sclk != cpol) act++;
                if (sclk != prev && sclk != cpol) begin
                    lead++;
                    if (cpha) begin
                        if (k < n) slave_bit = sdata[n-1-k];
                        k++;
                    end else begin
                        mosi_got = {mosi_got[62:0], mosi};
                    end
                    if (poke && lead == 1) begin
                        chk("cfg_rdy_busy", cfg_rdy, 0);
                        cfg_val = 1'b1;
                        cfg_mode = ~mode;
                        cfg_div = DIVW'(div + 1);
                        cfg_packet_size = LB'(n + 1);
                    end
                end else if (sclk != prev) begin
                    trail++;
                    if (cpha) begin
                        mosi_got = {mosi_got[62:0], mosi};
                    end else begin
                        if (k < n) slave_bit = sdata[n-1-k];
                        k++;
                    end
                end
                prev = sclk;
                @(negedge clk);
            end
        end
        chk("done_timeout", done, 1);
        chk("send_msg", 64'(send_msg), exp_rx);
        chk("cs_low_cycles", cs_low,
            (csa < NCS) ? (2 * n + 2) * (div + 1) : 0);
        chk("other_cs_low", other_bad, 0);
        chk("leading_edges", lead, n);
        chk("trailing_edges", trail, n);
        chk("sclk_active_cycles", act, n * (div + 1));
        if (csa < NCS) chk("mosi_bits", mosi_got, 64'(msg) & mask);
        for (int s = 0; s < stall; s++) begin
            recv_val = 1'b1;
            recv_msg = ~msg;
            @(negedge clk);
            chk("stall_send_val", send_val, 1);
            chk("stall_recv_rdy", recv_rdy, 0);
            chk("stall_send_msg", 64'(send_msg), exp_rx);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1);
    end

    initial begin
        logic [NB-1:0] m;
        int sz, dv, ca;
        logic [1:0] md;
        bit lp;
        recv_val = 0; recv_msg = '0; send_rdy = 1; cfg_val = 0;
        cfg_packet_size = '0; cfg_cs_addr = '0; cfg_mode = '0; cfg_div = '0;
        repeat (2) @(negedge clk);
        chk("rst_cs", cs, {NCS{1'b1}});
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_send_val", send_val, 0);
        chk("rst_send_msg", 64'(send_msg), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_recv_rdy", recv_rdy, 1);
        chk("rel_cfg_rdy", cfg_rdy, 1);

        xfer(NB'(34'h0A5), 8, 2'b00, 0, 0, 1, '0, 0, 0);
        gap(1);
        xfer(NB'(34'h9), 4, 2'b11, 3, 0, 0, '1, 0, 0);
        gap(2);
        xfer(NB'({$urandom, $urandom}), 0, 2'($urandom_range(0, 3)),
             1, 1, 0, {$urandom, $urandom}, 0, 0);
        gap(1);
        xfer(NB'({$urandom, $urandom}), 6, 2'b01, 1, 2, 0,
             {$urandom, $urandom}, 5, 0);
        xfer(NB'({$urandom, $urandom}), 5, 2'b00, 0, 0, 0,
             {$urandom, $urandom}, 0, 0);
        gap(1);
        xfer(NB'({$urandom, $urandom}), 12, 2'b10, 1, 2, 0,
             {$urandom, $urandom}, 0, 1);
        gap(1);
        xfer(NB'({$urandom, $urandom}), 40, 2'b01, 0, 1, 1, '0, 0, 0);
        xfer(NB'({$urandom, $urandom}), 7, 2'b11, 0, 3, 0,
             {$urandom, $urandom}, 0, 0);
        gap(1);

        for (int t = 0; t < 12; t++) begin
            m = NB'({$urandom, $urandom});
            sz = $urandom_range(0, 40);
            md = 2'($urandom_range(0, 3));
            dv = $urandom_range(0, 3);
            ca = $urandom_range(0, 3);
            lp = (ca < NCS) && ($urandom_range(0, 1) == 1);
            xfer(m, sz, md, dv, ca, lp, {$urandom, $urandom}, 0, 0);
            gap($urandom_range(0, 2));
        end

        gap(1);
        cfg_val = 1; cfg_packet_size = LB'(16); cfg_cs_addr = LC'(1);
        cfg_mode = 2'b00; cfg_div = DIVW'(2);
        recv_val = 1; recv_msg = NB'({$urandom, $urandom});
        @(negedge clk);
        cfg_val = 0; recv_val = 0;
        for (int c = 0; c < 20 && sclk !== 1'b1; c++) @(negedge clk);
        chk("reach_phase_a", sclk, 1);
        reset = 1'b0;
        #1;
        chk("abort_cs", cs, {NCS{1'b1}});
        chk("abort_sclk", sclk, 0);
        chk("abort_mosi", mosi, 0);
        chk("abort_send_val", send_val, 0);
        repeat (2) @(negedge clk);
        chk("abort_no_send", send_val, 0);
        reset = 1'b1;
        #1;
        chk("post_rst_recv_rdy", recv_rdy, 1);
        chk("post_rst_cfg_rdy", cfg_rdy, 1);
        xfer(NB'({$urandom, $urandom}), 8, 2'($urandom_range(0, 3)),
             1, 0, 0, {$urandom, $urandom}, 0, 0);
        gap(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
